// File: rtl/bram_port_arbiter.sv
// Clear sequencer and round-robin two-requester arbiter for one block-RAM port.
// Define BRAM_ARB_CLEAR_EN to zero the whole memory after reset before serving requests.
module bram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req0_en_i,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_rdy_o,
    input  logic                  req1_en_i,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_rdy_o,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_data_o,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_data_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_di_o,
    input  logic [DATA_WIDTH-1:0] mem_do_i,
    output logic                  init_o
);

    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("DEPTH exceeds the address space");
    end

    logic                  run;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc0, acc1;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;

`ifdef BRAM_ARB_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [ADDR_WIDTH:0] ClrLast = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == StClear) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == ClrLast) begin
                state_d = StRun;
            end
        end
    end

    assign run      = (state_q == StRun);
    // Reset gates the clear write so the RAM port is quiet while reset is held.
    assign clearing = (state_q == StClear) && rst_ni;
    assign clr_addr = clr_addr_q[ADDR_WIDTH-1:0];
`else
    logic run_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign run      = run_q;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // A requester is ready when it would win, whether or not it is asking.
    assign req0_rdy_o = run && (!req1_en_i || last_grant_q);
    assign req1_rdy_o = run && (!req0_en_i || !last_grant_q);
    assign acc0       = req0_en_i && req0_rdy_o;
    assign acc1       = req1_en_i && req1_rdy_o;
    assign init_o     = run;

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        if (acc0) begin
            last_grant_d = 1'b0;
            rsp_valid_d  = !req0_we_i;
            rsp_id_d     = 1'b0;
        end else if (acc1) begin
            last_grant_d = 1'b1;
            rsp_valid_d  = !req1_we_i;
            rsp_id_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    always_comb begin
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = req0_addr_i;
        mem_di_o   = req0_data_i;
        if (clearing) begin
            mem_en_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = clr_addr;
            mem_di_o   = '0;
        end else if (acc0) begin
            mem_en_o = 1'b1;
            mem_we_o = req0_we_i;
        end else if (acc1) begin
            mem_en_o   = 1'b1;
            mem_we_o   = req1_we_i;
            mem_addr_o = req1_addr_i;
            mem_di_o   = req1_data_i;
        end
    end

    assign rsp0_valid_o = rsp_valid_q && !rsp_id_q;
    assign rsp1_valid_o = rsp_valid_q && rsp_id_q;
    assign rsp0_data_o  = mem_do_i;
    assign rsp1_data_o  = mem_do_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: RAM model, per-cycle behavioural checker and directed tests.
// Follows BRAM_ARB_CLEAR_EN to pick the clear or no-clear expectations.
module tb_bram_port_arbiter;
    localparam int unsigned DW    = 36;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en0, we0, en1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          rdy0, rdy1, rsp0_v, rsp1_v, mem_en, mem_we, init;
    logic [DW-1:0] rsp0_d, rsp1_d, mem_di, mem_do;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_en_i(en0), .req0_we_i(we0), .req0_addr_i(addr0), .req0_data_i(data0),
        .req0_rdy_o(rdy0),
        .req1_en_i(en1), .req1_we_i(we1), .req1_addr_i(addr1), .req1_data_i(data1),
        .req1_rdy_o(rdy1),
        .rsp0_valid_o(rsp0_v), .rsp0_data_o(rsp0_d),
        .rsp1_valid_o(rsp1_v), .rsp1_data_o(rsp1_d),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_di_o(mem_di),
        .mem_do_i(mem_do), .init_o(init)
    );

    // Block RAM port driven by the DUT.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_di;
            else        mem_do <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Winner under round-robin rules: {granted, id}.
    function automatic logic [1:0] pick(input logic e0, input logic e1, input logic last);
        if (e0 && e1) return {1'b1, ~last};
        if (e0)       return 2'b10;
        if (e1)       return 2'b11;
        return 2'b00;
    endfunction

    // Behavioural model state.
    int            edges;
    logic          last;
    logic          pend_v, pend_id;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] shadow [2**AW];
    logic          m_run;
    logic [1:0]    g;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {init, rdy0, rdy1, mem_en, mem_we, rsp0_v, rsp1_v}, 7'b0);
            edges  = 0;
            last   = 1'b1;
            pend_v = 1'b0;
        end else begin
`ifdef BRAM_ARB_CLEAR_EN
            m_run = (edges >= DEPTH);
`else
            m_run = (edges >= 1);
`endif
            check("rsp_valid", {rsp0_v, rsp1_v}, {pend_v && !pend_id, pend_v && pend_id});
            if (pend_v) check("rsp_data", pend_id ? rsp1_d : rsp0_d, pend_data);
            check("init", init, m_run);
            pend_v = 1'b0;
            if (!m_run) begin
`ifdef BRAM_ARB_CLEAR_EN
                check("clear_bus", {rdy0, rdy1, mem_en, mem_we, mem_addr, mem_di},
                      {4'b0011, AW'(edges), DW'(0)});
                shadow[edges] = '0;
`else
                check("idle_bus", {rdy0, rdy1, mem_en, mem_we}, 4'b0);
`endif
            end else begin
                check("rdy", {rdy0, rdy1},
                      {pick(1'b1, en1, last) == 2'b10, pick(en0, 1'b1, last) == 2'b11});
                g      = pick(en0, en1, last);
                g_we   = g[0] ? we1 : we0;
                g_addr = g[0] ? addr1 : addr0;
                g_data = g[0] ? data1 : data0;
                check("mem_en_we", {mem_en, mem_we}, {g[1], g[1] && g_we});
                if (g[1]) begin
                    check("mem_addr", mem_addr, g_addr);
                    if (g_we) check("mem_di", mem_di, g_data);
                    last = g[0];
                    if (g_we) begin
                        shadow[g_addr] = g_data;
                    end else begin
                        pend_v    = 1'b1;
                        pend_id   = g[0];
                        pend_data = shadow[g_addr];
                    end
                end
            end
            edges++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en0 = 1'b0; we0 = 1'b0; en1 = 1'b0; we1 = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2**AW; i++) begin
`ifdef BRAM_ARB_CLEAR_EN
            ram[i]    = 36'hDEADBEEF;
            shadow[i] = 'x;
`else
            ram[i]    = DW'(i * 7);
            shadow[i] = DW'(i * 7);
`endif
        end
        idle();
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        repeat (3) tick();
        check("reset_vals", {init, rdy0, rdy1, mem_en, mem_we, rsp0_v, rsp1_v}, 7'b0);

`ifdef BRAM_ARB_CLEAR_EN
        rst_n = 1'b1;
        repeat (200) tick();
        check("clear_addr_200", {mem_en, mem_we, mem_addr}, {2'b11, 9'd200});
        rst_n = 1'b0;
        #1;
        check("midclear_reset", {init, mem_en}, 2'b00);
        tick();
        rst_n = 1'b1;
        #1;
        check("clear_restart", {mem_en, mem_addr}, {1'b1, 9'd0});
        n = 0;
        while (!init && n < 600) begin
            tick();
            n++;
        end
        check("clear_cycles", n, 512);
        en0 = 1'b1; addr0 = 9'd5;
        tick();
        idle();
        check("read_after_clear", {rsp0_v, rsp0_d}, {1'b1, 36'h0});
`else
        rst_n = 1'b1;
        #1;
        check("init_before_edge", init, 1'b0);
        tick();
        check("init_first_cycle", {init, rdy0}, 2'b11);
        en0 = 1'b1; addr0 = 9'd3;
        tick();
        idle();
        check("first_read", {rsp0_v, rsp1_v, rsp0_d}, {2'b10, 36'd21});
`endif

        // Preload through requester 1 so requester 0 wins the first tie.
        en1 = 1'b1; we1 = 1'b1; addr1 = 9'd1; data1 = 36'hA;
        tick();
        addr1 = 9'd2; data1 = 36'hB;
        tick();
        we1 = 1'b0; en0 = 1'b1; addr0 = 9'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_grant", {mem_en, mem_addr}, {1'b1, (i % 2 == 1) ? 9'd2 : 9'd1});
            if (i > 0) begin
                if (i % 2 == 1) check("tie_rsp0", {rsp0_v, rsp1_v, rsp0_d}, {2'b10, 36'hA});
                else            check("tie_rsp1", {rsp0_v, rsp1_v, rsp1_d}, {2'b01, 36'hB});
            end
            tick();
        end
        idle();
        #1;
        check("tie_rsp_last", {rsp0_v, rsp1_v, rsp1_d}, {2'b01, 36'hB});

        en1 = 1'b1; addr1 = 9'd2;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rdy1 && mem_en && !mem_we && mem_addr == 9'd2) n++;
            tick();
        end
        check("single_grants", n, 4);

        idle();
        en0 = 1'b1; we0 = 1'b1; addr0 = 9'd7; data0 = 36'h123456789;
        tick();
        idle();
        en1 = 1'b1; addr1 = 9'd7;
        tick();
        idle();
        check("write_then_read", {rsp0_v, rsp1_v, rsp1_d}, {2'b01, 36'h123456789});

        en0 = 1'b1; addr0 = 9'd7;
        en1 = 1'b1; we1 = 1'b1; addr1 = 9'd9; data1 = 36'h55;
        tick();
        tick();
        idle();
        tick();

        en0 = 1'b1; addr0 = 9'd9;
        tick();
        idle();
        check("read_back_9", {rsp0_v, rsp0_d}, {1'b1, 36'h55});
        rst_n = 1'b0;
        #1;
        check("midread_reset", {init, rdy0, rdy1, mem_en, rsp0_v, rsp1_v}, 6'b0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
